serial_nibble_adder: RTL and testbench

Multi-nibble serial adder controller. It accepts two wide operands and a carry-in over a valid/ready handshake. It then streams them LSB-nibble-first through a 4-bit add-with-carry stage, one nibble per clock, and presents the assembled sum and final carry over a valid/ready output handshake. It sits directly around the 4-bit ripple adder: it drives that adder's operand and carry inputs and consumes its `{c_out, sum}` result, so wide additions reuse a single narrow adder.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_nibble_adder_nibble_add.sv | 14 +
 rtl/serial_nibble_adder.sv | 144 ++++++++++++++
 tb/tb_serial_nibble_adder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial nibble adder: nibble width and FSM state encodings.
package serial_add_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_nibble_adder_nibble_add.sv
// Purely combinational 4-bit add with carry-in producing {c_out, sum}.
module nibble_add
   import serial_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                c_in,
   output logic [NIBBLE_W-1:0] sum,
   output logic                c_out
);

   assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c_in};

endmodule

// File: rtl/serial_nibble_adder.sv
// Wide adder that streams operands LSB-nibble-first through one shared nibble_add stage.
// Optional signed overflow output is enabled by defining SERIAL_ADD_OVERFLOW_EN.
module serial_nibble_adder
   import serial_add_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
   input  logic                      carry_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] result,
`ifdef SERIAL_ADD_OVERFLOW_EN
   output logic                      overflow,
`endif
   output logic                      carry_out
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int CNT_W = $clog2(NIBBLES + 1);

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       res_q, res_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [NIBBLE_W-1:0] sum_s;
   logic               c_out_s;
`ifdef SERIAL_ADD_OVERFLOW_EN
   logic               ovf_q, ovf_d;
`endif

   nibble_add u_nibble_add (
      .a     (a_q[NIBBLE_W-1:0]),
      .b     (b_q[NIBBLE_W-1:0]),
      .c_in  (carry_q),
      .sum   (sum_s),
      .c_out (c_out_s)
   );

   // Next-state, datapath shifting and registered handshake flags
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               carry_d = carry_in;
               cnt_d   = {CNT_W{1'b0}};
               state_d = ADD;
            end else begin
               state_d = IDLE;
            end
         end
         ADD: begin
            // sum enters at the top so after NIBBLES shifts nibble 0 sits at the bottom
            res_d   = (res_q >> NIBBLE_W) | (W'(sum_s) << (W - NIBBLE_W));
            a_d     = a_q >> NIBBLE_W;
            b_d     = b_q >> NIBBLE_W;
            carry_d = c_out_s;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NIBBLES - 1)) begin
               state_d = DONE;
`ifdef SERIAL_ADD_OVERFLOW_EN
               ovf_d   = (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) &&
                         (sum_s[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
`endif
            end else begin
               state_d = ADD;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
`ifdef SERIAL_ADD_OVERFLOW_EN
               ovf_d   = 1'b0;
`endif
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= {W{1'b0}};
         b_q         <= {W{1'b0}};
         res_q       <= {W{1'b0}};
         carry_q     <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef SERIAL_ADD_OVERFLOW_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign carry_out = carry_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
   assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed scoreboard bench for serial_nibble_adder (NIBBLES=4); overflow checks follow SERIAL_ADD_OVERFLOW_EN.
module tb_serial_nibble_adder;

   typedef struct packed {
      logic [15:0] res;
      logic        co;
      logic        ov;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        carry_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        carry_out;
`ifdef SERIAL_ADD_OVERFLOW_EN
   logic        overflow;
`endif

   exp_t sb[$];
   int   n_vec;
   int   n_err;

   serial_nibble_adder #(.NIBBLES(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
`ifdef SERIAL_ADD_OVERFLOW_EN
      .overflow  (overflow),
`endif
      .carry_out (carry_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction: accept, latency check, optional backpressure, result and handshake
   task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int hold, input logic early);
      exp_t        e;
      logic [16:0] full;
      int          cyc;
      @(negedge clock);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      e.res = full[15:0];
      e.co  = full[16];
      e.ov  = (a[15] == b[15]) && (full[15] != a[15]);
      sb.push_back(e);
      op_a = a; op_b = b; carry_in = cin; in_valid = 1'b1; out_ready = early;
      @(negedge clock);
      in_valid = 1'b0;
      cyc = 0;
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      while (out_valid !== 1'b1 && cyc < 20) begin
         @(negedge clock);
         cyc++;
      end
      chk("latency", cyc, 32'd4);
      e = sb.pop_front();
      if (!early) begin
         for (int i = 0; i < hold; i++) begin
            op_a = 16'($urandom); op_b = 16'($urandom); carry_in = 1'($urandom); in_valid = 1'b1;
            @(negedge clock);
            chk("bp_result_stable", {16'd0, result}, {16'd0, e.res});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      chk("result", {16'd0, result}, {16'd0, e.res});
      chk("carry_out", {31'd0, carry_out}, {31'd0, e.co});
`ifdef SERIAL_ADD_OVERFLOW_EN
      chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
`endif
      @(negedge clock);
      out_ready = 1'b0;
      chk("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
      chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = 16'h0000; op_b = 16'h0000; carry_in = 1'b0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_carry_out", {31'd0, carry_out}, 32'd0);
`ifdef SERIAL_ADD_OVERFLOW_EN
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
`endif
      #20;
      @(negedge clock);
      reset = 1'b0;

      run_add(16'h1234, 16'h1111, 1'b0, 0, 1'b0);
      run_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      run_add(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
      run_add(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
      run_add(16'h5A5A, 16'h0F0F, 1'b1, 5, 1'b0);
      run_add(16'hABCD, 16'h6789, 1'b1, 0, 1'b1);

      // Abort in the second ADD cycle
      @(negedge clock);
      op_a = 16'h1234; op_b = 16'h4321; carry_in = 1'b1; in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_result", {16'd0, result}, 32'd0);
      chk("abort_carry_out", {31'd0, carry_out}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      run_add(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

      run_add(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
      run_add(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      run_add(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         run_add(16'($urandom), 16'($urandom), 1'($urandom), 0, 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
